// File: rtl/smart_home_pkg.sv
// Shared smart-home definitions: SPI master FSM encoding, CRC-8 constants and the
// single-bit CRC-8 update step used by the serial CRC engines.
package smart_home_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  localparam logic [7:0] CRC8_POLY      = 8'h07;
  localparam logic       SPI_SCK_IDLE   = 1'b0;
  localparam logic       SPI_SSEL_IDLE  = 1'b1;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0): one bit per enable, synchronous clear
// taking priority over the update.
module crc8_serial
  import smart_home_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      crc_q <= 8'h00;
    else if (clr_i) crc_q <= 8'h00;
    else if (en_i)  crc_q <= crc8_step(crc_q, din_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: sends a FRAME_BYTES status frame MSB first and captures MISO.
// Define SPI_TX_CRC8_EN to append a CRC-8 byte and check the one received.
module spi_master_tx
  import smart_home_pkg::*;
#(
  parameter int FRAME_BYTES = 5,
  parameter int CLK_DIV     = 25,
  parameter int CS_GAP      = 50
) (
  input  logic                     clk50M,
  input  logic                     rst,
  input  logic [8*FRAME_BYTES-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [8*FRAME_BYTES-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     rx_crc_err,
  output logic                     SCK,
  output logic                     MOSI,
  input  logic                     MISO,
  output logic                     SSEL
);

  localparam int PAY_BITS = 8*FRAME_BYTES;
`ifdef SPI_TX_CRC8_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int N_BITS  = PAY_BITS + CRC_BITS;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(N_BITS - 1);

  spi_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [PAY_BITS-1:0] tx_sr_q;
  logic [N_BITS-1:0]   rx_sr_q;
  logic [PAY_BITS-1:0] rxd_q;
  logic                sck_q, ssel_q, mosi_q, ready_q, rxv_q;
  logic                miso_meta_q, miso_sync_q;
  logic                div_wrap, sck_rise, accept, next_mosi;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign div_wrap = (cnt_q == DIV_LAST);
  assign sck_rise = (state_q == ST_SHIFT) && div_wrap && !sck_q;
  assign accept   = (state_q == ST_IDLE) && tx_valid && ready_q;

`ifdef SPI_TX_CRC8_EN
  logic [7:0]       tx_crc, rx_crc;
  logic [BIT_W-1:0] nxt_bit;
  logic             crc_en;
  logic             crc_err_q;

  // Both CRCs advance on the sampling edge of payload bits only, so the tx CRC
  // is final one half-period before its first bit has to go out.
  assign crc_en = sck_rise && (bit_q >= BIT_W'(8));

  crc8_serial u_tx_crc (
    .clk_i(clk50M), .rst_i(rst), .clr_i(accept), .en_i(crc_en),
    .din_i(mosi_q), .crc_o(tx_crc)
  );

  crc8_serial u_rx_crc (
    .clk_i(clk50M), .rst_i(rst), .clr_i(accept), .en_i(crc_en),
    .din_i(miso_sync_q), .crc_o(rx_crc)
  );

  assign nxt_bit    = bit_q - 1'b1;
  assign next_mosi  = (nxt_bit < BIT_W'(8)) ? tx_crc[nxt_bit[2:0]] : tx_sr_q[PAY_BITS-2];
  assign rx_crc_err = crc_err_q;
`else
  assign next_mosi  = tx_sr_q[PAY_BITS-2];
  assign rx_crc_err = 1'b0;
`endif

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      rxd_q   <= '0;
      sck_q   <= SPI_SCK_IDLE;
      ssel_q  <= SPI_SSEL_IDLE;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      rxv_q   <= 1'b0;
`ifdef SPI_TX_CRC8_EN
      crc_err_q <= 1'b0;
`endif
    end else begin
      rxv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            tx_sr_q <= tx_data;
            mosi_q  <= tx_data[PAY_BITS-1];
            ssel_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= BIT_TOP;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_wrap) begin
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_wrap) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_sr_q <= {rx_sr_q[N_BITS-2:0], miso_sync_q};
            end else if (bit_q == '0) begin
              mosi_q  <= 1'b0;
              state_q <= ST_HOLD;
            end else begin
              bit_q   <= bit_q - 1'b1;
              tx_sr_q <= tx_sr_q << 1;
              mosi_q  <= next_mosi;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_wrap) begin
            cnt_q   <= '0;
            ssel_q  <= 1'b1;
            rxv_q   <= 1'b1;
            rxd_q   <= rx_sr_q[N_BITS-1 -: PAY_BITS];
`ifdef SPI_TX_CRC8_EN
            crc_err_q <= (rx_crc != rx_sr_q[7:0]);
`endif
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign SSEL     = ssel_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Randomized bench for spi_master_tx: a 5-byte/CLK_DIV=25 instance and a
// 1-byte/CLK_DIV=2 instance, checked against a bit-stream/CRC reference model.
`timescale 1ns/1ps
module tb_spi_master_tx;

`ifdef SPI_TX_CRC8_EN
  localparam int CRCB = 8;
`else
  localparam int CRCB = 0;
`endif
  localparam int FB  = 5, CD  = 25, GAP  = 50;
  localparam int PB  = 8*FB, NB = PB + CRCB;
  localparam int CD2 = 2, GAP2 = 4;
  localparam int NB2 = 8 + CRCB;

  logic clk50M = 1'b0;
  always #10 clk50M = ~clk50M;
  logic rst = 1'b0;
  int   cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // ---- DUT A: default parameters
  logic [PB-1:0] tx_data_a = '0, rx_data_a;
  logic tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, crc_a, sck_a, mosi_a, miso_a, ssel_a;

  spi_master_tx #(.FRAME_BYTES(FB), .CLK_DIV(CD), .CS_GAP(GAP)) u_dut_a (
    .clk50M(clk50M), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_crc_err(crc_a), .SCK(sck_a), .MOSI(mosi_a), .MISO(miso_a), .SSEL(ssel_a)
  );

  // ---- DUT B: edge parameters, MISO held high
  logic [7:0] tx_data_b = '0, rx_data_b;
  logic tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, crc_b, sck_b, mosi_b, ssel_b;
  logic miso_b = 1'b1;

  spi_master_tx #(.FRAME_BYTES(1), .CLK_DIV(CD2), .CS_GAP(GAP2)) u_dut_b (
    .clk50M(clk50M), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_crc_err(crc_b), .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b), .SSEL(ssel_b)
  );

  // ---- link monitors (sole writers of their counters)
  int rises_a = 0, perbad_a = 0, rxv_cnt_a = 0, fall_a = 0, srise_a = 0, rrise_a = 0;
  int rxv_cyc_a = 0, last_a = 0;
  logic first_a = 1'b1, sck_pa = 1'b0, ssel_pa = 1'b1, rdy_pa = 1'b0;
  logic [63:0] cap_a = '0;

  always @(negedge clk50M) begin
    if (!ssel_a && ssel_pa) begin fall_a = cyc; first_a = 1'b1; end
    if (ssel_a && !ssel_pa) srise_a = cyc;
    if (tx_ready_a && !rdy_pa) rrise_a = cyc;
    if (sck_a && !sck_pa) begin
      if (!first_a && (cyc - last_a) != 2*CD) perbad_a++;
      first_a = 1'b0;
      last_a  = cyc;
      cap_a   = {cap_a[62:0], mosi_a};
      rises_a++;
    end
    if (rx_valid_a) begin rxv_cnt_a++; rxv_cyc_a = cyc; end
    sck_pa = sck_a; ssel_pa = ssel_a; rdy_pa = tx_ready_a;
  end

  int rises_b = 0, perbad_b = 0, rxv_cnt_b = 0, fall_b = 0, rxv_cyc_b = 0, last_b = 0;
  logic first_b = 1'b1, sck_pb = 1'b0, ssel_pb = 1'b1;
  logic [63:0] cap_b = '0;

  always @(negedge clk50M) begin
    if (!ssel_b && ssel_pb) begin fall_b = cyc; first_b = 1'b1; end
    if (sck_b && !sck_pb) begin
      if (!first_b && (cyc - last_b) != 2*CD2) perbad_b++;
      first_b = 1'b0;
      last_b  = cyc;
      cap_b   = {cap_b[62:0], mosi_b};
      rises_b++;
    end
    if (rx_valid_b) begin rxv_cnt_b++; rxv_cyc_b = cyc; end
    sck_pb = sck_b; ssel_pb = ssel_b;
  end

  // ---- slave side for DUT A: loopback (optionally one bit inverted) or a pattern
  logic        loop_m = 1'b1, inv_m = 1'b0;
  logic [63:0] pat_m = '0;
  int          base_a = 0, bper_a = 0, brxv_a = 0;
  int          midx;

  always_comb begin
    midx = NB - 1 - (rises_a - base_a);
    if (midx < 0)  midx = 0;
    if (midx > 63) midx = 63;
    miso_a = loop_m ? (mosi_a ^ (inv_m && midx == 3)) : pat_m[midx];
  end

  // ---- reference model
  function automatic logic [7:0] crc8_ref(input logic [63:0] d, input int nbytes);
    logic [7:0] c;
    c = 8'h00;
    for (int i = nbytes - 1; i >= 0; i--) begin
      c = c ^ d[8*i +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [63:0] stream_of(input logic [63:0] d, input int nbytes);
    logic [63:0] s;
    s = d;
    if (CRCB > 0) s = (s << 8) | 64'(crc8_ref(d, nbytes));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_a(input logic [PB-1:0] d);
    int t;
    t = 0;
    @(negedge clk50M);
    while (!tx_ready_a && t < 500) begin @(negedge clk50M); t++; end
    chk("ready_before_start", 64'(tx_ready_a), 64'd1);
    base_a = rises_a; bper_a = perbad_a; brxv_a = rxv_cnt_a;
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    @(posedge clk50M); #1;
    tx_valid_a = 1'b0;
    tx_data_a  = PB'({$urandom(), $urandom()});
    chk("ssel_low_after_accept", 64'(ssel_a), 64'd0);
    chk("ready_drop_on_accept", 64'(tx_ready_a), 64'd0);
  endtask

  task automatic finish_a(input logic [PB-1:0] d);
    int t;
    logic [63:0] mask, rs, er;
    logic e;
    t = 0;
    while (rxv_cnt_a == brxv_a && t < 6000) begin @(negedge clk50M); t++; end
    chk("rx_valid_seen", 64'(rxv_cnt_a - brxv_a), 64'd1);
    mask = (64'd1 << NB) - 64'd1;
    rs   = loop_m ? (stream_of(64'(d), FB) ^ (inv_m ? 64'd8 : 64'd0)) : (pat_m & mask);
    er   = rs >> CRCB;
    e    = 1'b0;
    if (CRCB > 0) e = (crc8_ref(er, FB) != rs[7:0]);
    chk("sck_pulses", 64'(rises_a - base_a), 64'(NB));
    chk("sck_period", 64'(perbad_a - bper_a), 64'd0);
    chk("mosi_stream", cap_a & mask, stream_of(64'(d), FB));
    chk("rxv_latency", 64'(rxv_cyc_a - fall_a), 64'((2*NB + 2)*CD));
    chk("rx_data", 64'(rx_data_a), er);
    chk("rx_crc_err", 64'(crc_a), 64'(e));
  endtask

  initial begin
    logic [PB-1:0] d;
    int t;
    #(100000 * 20);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PB-1:0] d;
    int t, bb, bpb, brb;
    logic [63:0] mask;

    // reset state
    #5 rst = 1'b1; #1;
    chk("rst_ssel", 64'(ssel_a), 64'd1);
    chk("rst_sck", 64'(sck_a), 64'd0);
    chk("rst_mosi", 64'(mosi_a), 64'd0);
    chk("rst_ready", 64'(tx_ready_a), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid_a), 64'd0);
    chk("rst_rx_data", 64'(rx_data_a), 64'd0);
    chk("rst_crc_err", 64'(crc_a), 64'd0);
    repeat (3) @(negedge clk50M);
    rst = 1'b0; #1;
    chk("ready_still_low", 64'(tx_ready_a), 64'd0);
    @(posedge clk50M); #1;
    chk("ready_rise_1cyc", 64'(tx_ready_a), 64'd1);

    // handshake timing and loopback
    loop_m = 1'b1;
    start_a(40'hA5_3C_00_FF_81); finish_a(40'hA5_3C_00_FF_81);
    start_a(40'h01_23_45_67_89); finish_a(40'h01_23_45_67_89);

    // randomized frames against a random slave reply
    for (int i = 0; i < 5; i++) begin
      loop_m = 1'b0;
      pat_m  = {$urandom(), $urandom()};
      if (CRCB > 0 && $urandom_range(0, 1) == 1)
        pat_m[7:0] = crc8_ref((pat_m & ((64'd1 << NB) - 64'd1)) >> CRCB, FB);
      d = PB'({$urandom(), $urandom()});
      start_a(d); finish_a(d);
    end
    loop_m = 1'b1;

    // busy rejection
    d = PB'({$urandom(), $urandom()});
    start_a(d);
    t = 0;
    while ((rises_a - base_a) < 10 && t < 3000) begin @(negedge clk50M); t++; end
    tx_data_a  = '1;
    tx_valid_a = 1'b1;
    chk("busy_ready_low", 64'(tx_ready_a), 64'd0);
    finish_a(d);
    @(negedge clk50M);
    tx_valid_a = 1'b0;
    t = 0;
    while (!tx_ready_a && t < 500) begin @(negedge clk50M); t++; end
    @(negedge clk50M);
    chk("gap_to_ready", 64'(rrise_a - srise_a), 64'(GAP));
    chk("single_rx_pulse", 64'(rxv_cnt_a - brxv_a), 64'd1);

    // reset mid-frame
    d = PB'({$urandom(), $urandom()});
    start_a(d);
    t = 0;
    while ((rises_a - base_a) < 23 && t < 3000) begin @(negedge clk50M); t++; end
    rst = 1'b1; #1;
    chk("midrst_ssel", 64'(ssel_a), 64'd1);
    chk("midrst_sck", 64'(sck_a), 64'd0);
    chk("midrst_ready", 64'(tx_ready_a), 64'd0);
    repeat (3) @(negedge clk50M);
    rst = 1'b0;
    repeat (300) @(negedge clk50M);
    chk("midrst_no_rx_valid", 64'(rxv_cnt_a - brxv_a), 64'd0);
    chk("midrst_rx_data", 64'(rx_data_a), 64'd0);
    start_a(40'h55_55_55_55_55); finish_a(40'h55_55_55_55_55);

`ifdef SPI_TX_CRC8_EN
    start_a(40'h00_00_00_00_01); finish_a(40'h00_00_00_00_01);
    chk("crc_byte", {56'd0, cap_a[7:0]}, 64'h07);
    inv_m = 1'b1;
    start_a(40'h00_00_00_00_01); finish_a(40'h00_00_00_00_01);
    inv_m = 1'b0;
`endif

    // edge parameters on DUT B
    @(negedge clk50M);
    t = 0;
    while (!tx_ready_b && t < 100) begin @(negedge clk50M); t++; end
    bb = rises_b; bpb = perbad_b; brb = rxv_cnt_b;
    tx_data_b  = 8'h80;
    tx_valid_b = 1'b1;
    @(posedge clk50M); #1;
    tx_valid_b = 1'b0;
    tx_data_b  = 8'h3C;
    t = 0;
    while (rxv_cnt_b == brb && t < 500) begin @(negedge clk50M); t++; end
    mask = (64'd1 << NB2) - 64'd1;
    chk("b_rx_valid_seen", 64'(rxv_cnt_b - brb), 64'd1);
    chk("b_sck_pulses", 64'(rises_b - bb), 64'(NB2));
    chk("b_sck_period", 64'(perbad_b - bpb), 64'd0);
    chk("b_mosi_stream", cap_b & mask, stream_of(64'h80, 1));
    chk("b_rxv_latency", 64'(rxv_cyc_b - fall_b), 64'((2*NB2 + 2)*CD2));
    chk("b_rx_data", 64'(rx_data_b), 64'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
